pci_target_responder: RTL
=========================

// Module: pci_target_responder
// PURPOSE
//  PCI target (responder) for the lab bus: decodes master address phases, claims hits
//  with fast DEVSEL_, paces data phases with TRDY_, and serves single/burst memory reads
//  and writes to a small internal register file. Opposite end of the master driving
//  FRAME_/IRDY_; its outputs must satisfy the bus protocol property checks.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  byte base address of the decoded window
//  ADDR_BITS    4              log2 of word count (16 x 32-bit regs, 64-byte window)
//  WAIT_STATES  2              TRDY_ wait cycles before the first data phase (0..3)
// PORTS
//  clk       in   1   bus clock; all sampling on posedge
//  reset     in   1   asynchronous, active-high reset
//  FRAME_    in   1   master frame, active low
//  IRDY_     in   1   master ready, active low
//  C_BE_     in   4   command (addr phase) / byte enables, active low (data phases)
//  ad_in     in   32  AD bus as sampled
//  ad_out    out  32  read data driven onto AD
//  ad_oe     out  1   1 = drive ad_out onto AD
//  DEVSEL_   out  1   device select, active low
//  TRDY_     out  1   target ready, active low
// BEHAVIOUR
//  Reset (async, immediate): DEVSEL_=1, TRDY_=1, ad_oe=0, ad_out=0, all regs=0, state IDLE.
//  Address phase: posedge where FRAME_ sampled low and was high on previous posedge.
//   Latch idx=ad_in[ADDR_BITS+1:2], cmd=C_BE_. Hit iff cmd in {4'b0110 mem rd,
//   4'b0111 mem wr} and ad_in[31:ADDR_BITS+2]==BASE_ADDR[31:ADDR_BITS+2].
//  States: IDLE, WAIT, DATA, TURN, IGNORE.
//   IDLE  : hit -> WAIT (or DATA if WAIT_STATES==0); miss -> IGNORE.
//   IGNORE: outputs idle; -> IDLE when FRAME_=1 and IRDY_=1 sampled.
//   WAIT  : DEVSEL_=0, TRDY_=1; count WAIT_STATES cycles -> DATA.
//   DATA  : DEVSEL_=0, TRDY_=0. Transfer on posedge with IRDY_=0 and TRDY_=0.
//           Transfer with FRAME_=1 is last -> TURN; else idx=idx+1 (wraps mod
//           2**ADDR_BITS), stay DATA (zero wait states after first phase).
//           IRDY_=1: hold TRDY_ low, idx and ad_out unchanged.
//   TURN  : DEVSEL_=1, TRDY_=1, ad_oe=0 for one cycle -> IDLE.
//  Timing: DEVSEL_ falls the cycle after address phase (fast decode); first TRDY_ fall
//   is WAIT_STATES cycles after DEVSEL_ fall. TRDY_ never low while DEVSEL_ high.
//  Write: on transfer, reg[idx] byte i <= ad_in byte i where C_BE_[i]==0; C_BE_=4'b1111
//   transfers with no update.
//  Read: ad_oe=1 from first WAIT/DATA cycle (one turnaround cycle after address phase)
//   through last data phase; ad_out=reg[idx] registered, valid whenever TRDY_=0.
//   Byte enables ignored on read (full word driven).
//  New FRAME_ fall seen in TURN: ignored (master must leave one idle cycle).
//  Reset mid-transaction: outputs idle same instant; after release, IDLE waits for a fresh
//   FRAME_ falling edge; an in-progress transaction is never resumed.
// TESTING
//  1. Assert reset -> DEVSEL_=1, TRDY_=1, ad_oe=0, ad_out=0 without clock edge.
//  2. Write 0x1008, data 0xDEADBEEF, C_BE_=0000, WAIT_STATES=2 -> DEVSEL_ low cycle 1,
//     TRDY_ low cycle 3, reg[2]=0xDEADBEEF, TURN then IDLE.
//  3. Write 0x1008, data 0x12345678, C_BE_=4'b1100 -> reg[2]=0xDEAD5678.
//  4. Burst read 3 words from 0x103C, master holds IRDY_ high one cycle in phase 2 ->
//     ad_out=reg[15],reg[0],reg[1]; TRDY_ stays low, ad_out stable during IRDY_ stall.
//  5. Miss: mem read to 0x1040, and cmd 4'b0010 to 0x1000 -> DEVSEL_/TRDY_ stay 1, ad_oe=0
//     for whole transaction; next hit decoded normally.
//  6. Reset pulse mid-burst at phase 2 -> outputs idle immediately; regs cleared;
//     following write to 0x1000 completes normally.

Source files
------------

// File: rtl/pci_target_responder.sv
// pci_target_responder
//   PCI memory target for the lab bus. It decodes master address phases, claims
//   hits in a 2**ADDR_BITS-word window with fast DEVSEL_, inserts WAIT_STATES
//   TRDY_ wait cycles before the first data phase, and then serves single or burst
//   reads and writes to a small internal register file. Bursts advance the word
//   index by one per transfer and wrap inside the window.
//
// Ports
//   clk      in   bus clock, everything sampled on posedge
//   reset    in   asynchronous active-high reset
//   FRAME_   in   master frame (active low)
//   IRDY_    in   master ready (active low)
//   C_BE_    in   [3:0] command in the address phase, byte enables (active low) after
//   ad_in    in   [31:0] AD bus as sampled
//   ad_out   out  [31:0] read data for AD
//   ad_oe    out  1 = drive ad_out onto AD
//   DEVSEL_  out  device select (active low)
//   TRDY_    out  target ready (active low)
module pci_target_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          ADDR_BITS   = 4,
  parameter int          WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        FRAME_,
  input  logic        IRDY_,
  input  logic [3:0]  C_BE_,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        DEVSEL_,
  output logic        TRDY_
);

  localparam int          NUM_WORDS  = 1 << ADDR_BITS;
  localparam logic [3:0]  CMD_MEM_RD = 4'b0110;
  localparam logic [3:0]  CMD_MEM_WR = 4'b0111;
  // WAIT is left when the counter reaches zero, so it is preloaded with N-1.
  localparam logic [1:0]  WAIT_LOAD  = (WAIT_STATES == 0) ? 2'd0 : 2'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_TURN,
    ST_IGNORE
  } state_t;

  state_t                 state_reg, state_next;
  logic                   frame_prev_reg;
  logic [ADDR_BITS-1:0]   idx_reg, idx_next;
  logic                   write_reg, write_next;
  logic [1:0]             wait_cnt_reg, wait_cnt_next;
  logic [31:0]            ad_out_reg, ad_out_next;
  logic [31:0]            mem_word [NUM_WORDS];

  logic                   addr_phase;
  logic                   addr_hit;
  logic [ADDR_BITS-1:0]   addr_idx;
  logic [ADDR_BITS-1:0]   idx_inc;
  logic                   transfer;

  // frame_prev_reg resets low so a FRAME_ still held low after reset is never
  // mistaken for a new address phase: only a fresh falling edge starts a cycle.
  assign addr_phase = !FRAME_ && frame_prev_reg;
  assign addr_idx   = ad_in[ADDR_BITS+1:2];
  assign addr_hit   = ((C_BE_ == CMD_MEM_RD) || (C_BE_ == CMD_MEM_WR)) &&
                      (ad_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign idx_inc    = idx_reg + ADDR_BITS'(1);
  // TRDY_ is low for the whole DATA state, so IRDY_ alone qualifies a transfer.
  assign transfer   = (state_reg == ST_DATA) && !IRDY_;

  // Register file: one word per generate slice, byte-lane writes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_reg <= '0;
        end else if (transfer && write_reg && (idx_reg == ADDR_BITS'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (!C_BE_[b]) begin
              word_reg[8*b +: 8] <= ad_in[8*b +: 8];
            end
          end
        end
      end

      assign mem_word[gi] = word_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      frame_prev_reg <= 1'b0;
      idx_reg        <= '0;
      write_reg      <= 1'b0;
      wait_cnt_reg   <= 2'd0;
      ad_out_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      frame_prev_reg <= FRAME_;
      idx_reg        <= idx_next;
      write_reg      <= write_next;
      wait_cnt_reg   <= wait_cnt_next;
      ad_out_reg     <= ad_out_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    write_next    = write_reg;
    wait_cnt_next = wait_cnt_reg;
    ad_out_next   = ad_out_reg;
    DEVSEL_       = 1'b1;
    TRDY_         = 1'b1;
    ad_oe         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (addr_phase) begin
          if (addr_hit) begin
            idx_next      = addr_idx;
            write_next    = (C_BE_ == CMD_MEM_WR);
            wait_cnt_next = WAIT_LOAD;
            // Prefetch the first read word so it is ready when TRDY_ first falls.
            if (C_BE_ == CMD_MEM_RD) begin
              ad_out_next = mem_word[addr_idx];
            end
            state_next = (WAIT_STATES == 0) ? ST_DATA : ST_WAIT;
          end else begin
            state_next = ST_IGNORE;
          end
        end
      end

      ST_WAIT: begin
        DEVSEL_ = 1'b0;
        ad_oe   = !write_reg;
        if (wait_cnt_reg == 2'd0) begin
          state_next = ST_DATA;
        end else begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
        end
      end

      ST_DATA: begin
        DEVSEL_ = 1'b0;
        TRDY_   = 1'b0;
        ad_oe   = !write_reg;
        if (transfer) begin
          if (FRAME_) begin
            state_next = ST_TURN;
          end else begin
            idx_next = idx_inc;
            if (!write_reg) begin
              ad_out_next = mem_word[idx_inc];
            end
          end
        end
      end

      ST_TURN: begin
        state_next = ST_IDLE;
      end

      ST_IGNORE: begin
        if (FRAME_ && IRDY_) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign ad_out = ad_out_reg;

endmodule
